// File: rtl/sample_framer_pkg.sv
// Shared constants and state types for the sample framer.
// Frames start with a fixed two-byte start-of-frame marker.
package sample_framer_pkg;

  localparam logic [7:0] Sof0Byte = 8'hA5;
  localparam logic [7:0] Sof1Byte = 8'h5A;

  typedef enum logic {
    CIdle,
    CRun
  } cap_state_e;

  typedef enum logic [2:0] {
    EIdle,
    ESof0,
    ESof1,
    ECnt,
    EHi,
    ELo
  } emit_state_e;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous 16-bit FIFO with first-word-fall-through read data and flush.
// Pushes while full and pops while empty are ignored; flush wins over both.
module sample_fifo #(
  parameter int unsigned DepthLog2 = 6
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        flush_i,
  input  logic        push_i,
  input  logic [15:0] wdata_i,
  input  logic        pop_i,
  output logic [15:0] rdata_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int unsigned Depth = 2 ** DepthLog2;

  logic [15:0]        mem_q [Depth];
  logic [DepthLog2:0] wptr_q, wptr_d;
  logic [DepthLog2:0] rptr_q, rptr_d;
  logic               do_push;
  logic               do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[DepthLog2] != rptr_q[DepthLog2]) &&
                   (wptr_q[DepthLog2-1:0] == rptr_q[DepthLog2-1:0]);
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign rdata_o = mem_q[rptr_q[DepthLog2-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + (DepthLog2 + 1)'(1);
      if (do_pop)  rptr_d = rptr_q + (DepthLog2 + 1)'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[DepthLog2-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/sample_framer.sv
// Captures one chirp's worth of decimated samples and streams them as a framed
// byte sequence (SOF, frame count, 16-bit samples MSB-first) over valid/ready.
module sample_framer
  import sample_framer_pkg::*;
#(
  parameter int unsigned DW                = 14,
  parameter int unsigned SAMPLES_PER_FRAME = 1024,
  parameter int unsigned SPF_WIDTH         = 10,
  parameter int unsigned FIFO_DEPTH_LOG2   = 6
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          ce_i,
  input  logic [DW-1:0] di_i,
  input  logic          di_valid_i,
  input  logic          chirp_start_i,
  output logic [7:0]    byte_o,
  output logic          byte_valid_o,
  input  logic          byte_ready_i,
  output logic          frame_done_o,
  output logic          busy_o,
  output logic          overflow_o
);

  localparam logic [SPF_WIDTH-1:0] LastIdx = SPF_WIDTH'(SAMPLES_PER_FRAME - 1);

  cap_state_e           cap_q, cap_d;
  emit_state_e          emit_q, emit_d;
  logic [SPF_WIDTH-1:0] cap_cnt_q, cap_cnt_d;
  logic [SPF_WIDTH-1:0] emit_cnt_q, emit_cnt_d;
  logic [SPF_WIDTH-1:0] cap_idx;
  logic [7:0]           byte_q, byte_d;
  logic                 valid_q, valid_d;
  logic                 done_q, done_d;
  logic                 ovf_q, ovf_d;
  logic [7:0]           frame_cnt_q, frame_cnt_d;

  logic        fifo_push, fifo_pop, fifo_flush;
  logic        fifo_full, fifo_empty;
  logic [15:0] fifo_rdata;
  logic [15:0] sample_ext;
  logic        start;
  logic        xfer;
  logic        write;
  logic        ovf_evt;

  assign sample_ext = 16'($signed(di_i));
  assign start      = chirp_start_i && (cap_q == CIdle) && (emit_q == EIdle);
  assign xfer       = valid_q && byte_ready_i;
  // A sample coinciding with the arming chirp is sample 0 of the frame.
  assign write      = di_valid_i && ((cap_q == CRun) || start);
  assign ovf_evt    = ce_i && write && fifo_full;

  sample_fifo #(
    .DepthLog2(FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .flush_i(fifo_flush),
    .push_i (fifo_push),
    .wdata_i(sample_ext),
    .pop_i  (fifo_pop),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  always_comb begin
    cap_d       = cap_q;
    cap_cnt_d   = cap_cnt_q;
    emit_d      = emit_q;
    emit_cnt_d  = emit_cnt_q;
    byte_d      = byte_q;
    valid_d     = valid_q;
    done_d      = 1'b0;
    ovf_d       = ovf_q;
    frame_cnt_d = frame_cnt_q;
    fifo_push   = 1'b0;
    fifo_pop    = 1'b0;
    fifo_flush  = 1'b0;
    cap_idx     = cap_cnt_q;

    if (!ce_i) begin
      cap_d      = CIdle;
      emit_d     = EIdle;
      valid_d    = 1'b0;
      byte_d     = 8'h00;
      fifo_flush = 1'b1;
    end else begin
      if (start) begin
        cap_d     = CRun;
        cap_cnt_d = '0;
        cap_idx   = '0;
      end
      if (write) begin
        if (fifo_full) begin
          ovf_d      = 1'b1;
          cap_d      = CIdle;
          fifo_flush = 1'b1;
        end else begin
          fifo_push = 1'b1;
          cap_cnt_d = cap_idx + SPF_WIDTH'(1);
          if (cap_idx == LastIdx) cap_d = CIdle;
        end
      end

      // Abort drops any pending byte; a byte transferring this cycle still completes.
      if (ovf_evt) begin
        emit_d      = EIdle;
        valid_d     = 1'b0;
        byte_d      = 8'h00;
        frame_cnt_d = frame_cnt_q + 8'd1;
      end else begin
        unique case (emit_q)
          EIdle: begin
            if (start) begin
              emit_d     = ESof0;
              emit_cnt_d = '0;
              byte_d     = Sof0Byte;
              valid_d    = 1'b1;
            end
          end
          ESof0: begin
            if (xfer) begin
              emit_d = ESof1;
              byte_d = Sof1Byte;
            end
          end
          ESof1: begin
            if (xfer) begin
              emit_d = ECnt;
              byte_d = frame_cnt_q;
            end
          end
          ECnt: begin
            if (xfer) begin
              emit_d  = EHi;
              valid_d = !fifo_empty;
              byte_d  = fifo_empty ? 8'h00 : fifo_rdata[15:8];
            end
          end
          EHi: begin
            if (!valid_q) begin
              if (!fifo_empty) begin
                valid_d = 1'b1;
                byte_d  = fifo_rdata[15:8];
              end
            end else if (xfer) begin
              // Low byte is latched here, so the head entry can be released now.
              emit_d   = ELo;
              byte_d   = fifo_rdata[7:0];
              fifo_pop = 1'b1;
            end
          end
          ELo: begin
            if (xfer) begin
              if (emit_cnt_q == LastIdx) begin
                emit_d      = EIdle;
                valid_d     = 1'b0;
                byte_d      = 8'h00;
                done_d      = 1'b1;
                frame_cnt_d = frame_cnt_q + 8'd1;
              end else begin
                emit_d     = EHi;
                emit_cnt_d = emit_cnt_q + SPF_WIDTH'(1);
                valid_d    = !fifo_empty;
                byte_d     = fifo_empty ? 8'h00 : fifo_rdata[15:8];
              end
            end
          end
          default: begin
            emit_d  = EIdle;
            valid_d = 1'b0;
            byte_d  = 8'h00;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cap_q       <= CIdle;
      emit_q      <= EIdle;
      cap_cnt_q   <= '0;
      emit_cnt_q  <= '0;
      byte_q      <= 8'h00;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      frame_cnt_q <= 8'h00;
    end else begin
      cap_q       <= cap_d;
      emit_q      <= emit_d;
      cap_cnt_q   <= cap_cnt_d;
      emit_cnt_q  <= emit_cnt_d;
      byte_q      <= byte_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = valid_q;
  assign frame_done_o = done_q;
  assign overflow_o   = ovf_q;
  assign busy_o       = (cap_q != CIdle) || (emit_q != EIdle);

endmodule

// File: tb/tb_sample_framer.sv
// Directed bench for sample_framer: three instances share stimulus, each
// configured for the scenarios it is checked against.
module tb_sample_framer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        ce = 1'b1;
  logic [13:0] di = '0;
  logic        di_valid = 1'b0;
  logic        chirp = 1'b0;
  logic        ready = 1'b1;

  logic [7:0] byte_a, byte_b, byte_c;
  logic       valid_a, valid_b, valid_c;
  logic       done_a, done_b, done_c;
  logic       busy_a, busy_b, busy_c;
  logic       ovf_a, ovf_b, ovf_c;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  logic [7:0] q_c[$];
  int done_cnt_a = 0, done_cnt_b = 0, done_cnt_c = 0;
  int done_cyc_a = 0, last_xfer_cyc_a = 0;

  logic [13:0] smp [4] = '{14'h0001, 14'h3FFF, 14'h2000, 14'h1FFF};
  logic [7:0] exp_basic [11] = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h01, 8'hFF, 8'hFF,
                                 8'hE0, 8'h00, 8'h1F, 8'hFF};

  sample_framer #(.DW(14), .SAMPLES_PER_FRAME(4), .SPF_WIDTH(10), .FIFO_DEPTH_LOG2(6)) u_dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .ce_i(ce), .di_i(di), .di_valid_i(di_valid),
    .chirp_start_i(chirp), .byte_o(byte_a), .byte_valid_o(valid_a), .byte_ready_i(ready),
    .frame_done_o(done_a), .busy_o(busy_a), .overflow_o(ovf_a));

  sample_framer #(.DW(14), .SAMPLES_PER_FRAME(8), .SPF_WIDTH(10), .FIFO_DEPTH_LOG2(2)) u_dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .ce_i(ce), .di_i(di), .di_valid_i(di_valid),
    .chirp_start_i(chirp), .byte_o(byte_b), .byte_valid_o(valid_b), .byte_ready_i(ready),
    .frame_done_o(done_b), .busy_o(busy_b), .overflow_o(ovf_b));

  sample_framer #(.DW(14), .SAMPLES_PER_FRAME(1), .SPF_WIDTH(10), .FIFO_DEPTH_LOG2(2)) u_dut_c (
    .clk_i(clk), .rst_n_i(rst_n), .ce_i(ce), .di_i(di), .di_valid_i(di_valid),
    .chirp_start_i(chirp), .byte_o(byte_c), .byte_valid_o(valid_c), .byte_ready_i(ready),
    .frame_done_o(done_c), .busy_o(busy_c), .overflow_o(ovf_c));

  always @(posedge clk) cyc <= cyc + 1;

  // valid && ready seen mid-cycle means the byte transfers on the next rising edge.
  always @(negedge clk) begin
    if (valid_a && ready) begin
      q_a.push_back(byte_a);
      last_xfer_cyc_a <= cyc;
    end
    if (valid_b && ready) q_b.push_back(byte_b);
    if (valid_c && ready) q_c.push_back(byte_c);
    if (done_a) begin
      done_cnt_a <= done_cnt_a + 1;
      done_cyc_a <= cyc;
    end
    if (done_b) done_cnt_b <= done_cnt_b + 1;
    if (done_c) done_cnt_c <= done_cnt_c + 1;
  end

  function automatic int done_of(input int which);
    if (which == 0) return done_cnt_a;
    if (which == 1) return done_cnt_b;
    return done_cnt_c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; ce = 1'b1; di = '0; di_valid = 1'b0; chirp = 1'b0; ready = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic send(input logic [13:0] v, input int gap);
    di = v; di_valid = 1'b1;
    tick();
    di_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic pulse_chirp();
    chirp = 1'b1;
    tick();
    chirp = 1'b0;
  endtask

  task automatic wait_done(input int which, input int target, input int budget);
    int n = 0;
    while (done_of(which) < target && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ce = 1'b1; di_valid = 1'b0; chirp = 1'b0; ready = 1'b1;
    tick();
    total++;
    if ({byte_a, valid_a, done_a, busy_a, ovf_a} !== 12'h000) begin
      bad++; $display("FAIL reset_a: got %h want 000", {byte_a, valid_a, done_a, busy_a, ovf_a});
    end
    total++;
    if ({byte_b, valid_b, done_b, busy_b, ovf_b} !== 12'h000) begin
      bad++; $display("FAIL reset_b: got %h want 000", {byte_b, valid_b, done_b, busy_b, ovf_b});
    end
    total++;
    if ({byte_c, valid_c, done_c, busy_c, ovf_c} !== 12'h000) begin
      bad++; $display("FAIL reset_c: got %h want 000", {byte_c, valid_c, done_c, busy_c, ovf_c});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_frame();
    int base, base2, d0;
    logic [7:0] got;
    apply_reset();
    base = q_a.size(); d0 = done_cnt_a;
    pulse_chirp();
    total++;
    if ({valid_a, byte_a} !== {1'b1, 8'hA5}) begin
      bad++; $display("FAIL sof_latency: got v=%b b=%h want v=1 b=a5", valid_a, byte_a);
    end
    repeat (3) tick();
    di = smp[0]; di_valid = 1'b1;
    tick();
    di_valid = 1'b0;
    total++;
    if (valid_a !== 1'b0) begin
      bad++; $display("FAIL hi_early: valid=%b want 0 one cycle after sample", valid_a);
    end
    tick();
    total++;
    if ({valid_a, byte_a} !== {1'b1, 8'h00}) begin
      bad++; $display("FAIL hi_latency: got v=%b b=%h want v=1 b=00", valid_a, byte_a);
    end
    for (int i = 1; i < 4; i++) send(smp[i], 2);
    wait_done(0, d0 + 1, 60);
    total++;
    if (q_a.size() - base !== 11) begin
      bad++; $display("FAIL basic_len: got %0d bytes want 11", q_a.size() - base);
    end
    for (int i = 0; i < 11; i++) begin
      got = (base + i < q_a.size()) ? q_a[base + i] : 8'hxx;
      total++;
      if (got !== exp_basic[i]) begin
        bad++; $display("FAIL basic_byte%0d: got %h want %h", i, got, exp_basic[i]);
      end
    end
    total++;
    if (done_cyc_a !== last_xfer_cyc_a + 1) begin
      bad++; $display("FAIL done_timing: done cycle %0d want %0d", done_cyc_a, last_xfer_cyc_a + 1);
    end
    repeat (3) tick();
    total++;
    if (done_cnt_a !== d0 + 1) begin
      bad++; $display("FAIL done_pulses: got %0d want %0d", done_cnt_a - d0, 1);
    end
    base2 = q_a.size();
    pulse_chirp();
    for (int i = 0; i < 4; i++) send(smp[i], 1);
    wait_done(0, d0 + 2, 60);
    got = (base2 + 2 < q_a.size()) ? q_a[base2 + 2] : 8'hxx;
    total++;
    if (got !== 8'h01) begin
      bad++; $display("FAIL second_count: got %h want 01", got);
    end
  endtask

  task automatic test_backpressure();
    int base, d0, n;
    logic [7:0] got;
    apply_reset();
    base = q_a.size(); d0 = done_cnt_a;
    pulse_chirp();
    repeat (3) tick();
    send(smp[0], 0);
    n = 0;
    while (!((q_a.size() - base == 4) && valid_a) && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (!((q_a.size() - base == 4) && valid_a)) begin
      bad++; $display("FAIL bp_reach_lo: got %0d bytes valid=%b want 4 bytes valid=1",
                      q_a.size() - base, valid_a);
    end
    ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 2 || i == 5 || i == 8) begin
        di = smp[(i + 1) / 3]; di_valid = 1'b1;
      end else begin
        di_valid = 1'b0;
      end
      tick();
      total++;
      if ({valid_a, byte_a} !== {1'b1, 8'h01}) begin
        bad++; $display("FAIL bp_hold%0d: got v=%b b=%h want v=1 b=01", i, valid_a, byte_a);
      end
    end
    di_valid = 1'b0;
    ready = 1'b1;
    wait_done(0, d0 + 1, 60);
    total++;
    if (q_a.size() - base !== 11) begin
      bad++; $display("FAIL bp_len: got %0d bytes want 11", q_a.size() - base);
    end
    for (int i = 0; i < 11; i++) begin
      got = (base + i < q_a.size()) ? q_a[base + i] : 8'hxx;
      total++;
      if (got !== exp_basic[i]) begin
        bad++; $display("FAIL bp_byte%0d: got %h want %h", i, got, exp_basic[i]);
      end
    end
  endtask

  task automatic test_overflow();
    int base, d0;
    logic [7:0] got;
    apply_reset();
    ready = 1'b0;
    pulse_chirp();
    for (int i = 0; i < 4; i++) send(14'h0100 + 14'(i), 1);
    total++;
    if ({ovf_b, busy_b} !== 2'b01) begin
      bad++; $display("FAIL ovf_pre: got ovf=%b busy=%b want ovf=0 busy=1", ovf_b, busy_b);
    end
    di = 14'h0104; di_valid = 1'b1;
    tick();
    di_valid = 1'b0;
    total++;
    if ({ovf_b, busy_b, valid_b} !== 3'b100) begin
      bad++; $display("FAIL ovf_post: got ovf=%b busy=%b valid=%b want 1 0 0",
                      ovf_b, busy_b, valid_b);
    end
    ready = 1'b1;
    tick();
    base = q_b.size(); d0 = done_cnt_b;
    pulse_chirp();
    for (int i = 0; i < 8; i++) send(14'h2A00 + 14'(i), 2);
    wait_done(1, d0 + 1, 80);
    total++;
    if (q_b.size() - base !== 19) begin
      bad++; $display("FAIL ovf_clean_len: got %0d bytes want 19", q_b.size() - base);
    end
    got = (base + 2 < q_b.size()) ? q_b[base + 2] : 8'hxx;
    total++;
    if (got !== 8'h01) begin
      bad++; $display("FAIL ovf_next_count: got %h want 01", got);
    end
    for (int i = 0; i < 8; i++) begin
      got = (base + 4 + 2 * i < q_b.size()) ? q_b[base + 4 + 2 * i] : 8'hxx;
      total++;
      if (got !== 8'(i)) begin
        bad++; $display("FAIL ovf_clean_lo%0d: got %h want %h", i, got, 8'(i));
      end
    end
    got = (base + 3 < q_b.size()) ? q_b[base + 3] : 8'hxx;
    total++;
    if (got !== 8'hEA) begin
      bad++; $display("FAIL ovf_clean_hi: got %h want ea", got);
    end
    total++;
    if (ovf_b !== 1'b1) begin
      bad++; $display("FAIL ovf_sticky: got %b want 1", ovf_b);
    end
  endtask

  task automatic test_gating();
    int base, d0;
    logic [7:0] got;
    apply_reset();
    base = q_a.size(); d0 = done_cnt_a;
    send(14'h1234, 1);
    send(14'h0BAD, 1);
    chirp = 1'b1; di = smp[0]; di_valid = 1'b1;
    tick();
    chirp = 1'b0; di_valid = 1'b0;
    tick();
    send(smp[1], 2);
    pulse_chirp();
    send(smp[2], 2);
    send(smp[3], 2);
    wait_done(0, d0 + 1, 60);
    repeat (20) tick();
    total++;
    if (q_a.size() - base !== 11) begin
      bad++; $display("FAIL gate_len: got %0d bytes want 11", q_a.size() - base);
    end
    for (int i = 0; i < 11; i++) begin
      got = (base + i < q_a.size()) ? q_a[base + i] : 8'hxx;
      total++;
      if (got !== exp_basic[i]) begin
        bad++; $display("FAIL gate_byte%0d: got %h want %h", i, got, exp_basic[i]);
      end
    end
    total++;
    if ({done_cnt_a - d0, busy_a} !== {32'd1, 1'b0}) begin
      bad++; $display("FAIL gate_frames: got %0d frames busy=%b want 1 busy=0",
                      done_cnt_a - d0, busy_a);
    end
  endtask

  task automatic test_reset_mid();
    int base, d0;
    logic [7:0] got;
    apply_reset();
    d0 = done_cnt_a;
    pulse_chirp();
    for (int i = 0; i < 4; i++) send(smp[i], 1);
    wait_done(0, d0 + 1, 60);
    pulse_chirp();
    repeat (3) tick();
    total++;
    if ({busy_a, valid_a} !== 2'b10) begin
      bad++; $display("FAIL rst_pre: got busy=%b valid=%b want 1 0", busy_a, valid_a);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({byte_a, valid_a, done_a, busy_a, ovf_a} !== 12'h000) begin
      bad++; $display("FAIL rst_async: got %h want 000", {byte_a, valid_a, done_a, busy_a, ovf_a});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    base = q_a.size(); d0 = done_cnt_a;
    pulse_chirp();
    for (int i = 0; i < 4; i++) send(smp[i], 1);
    wait_done(0, d0 + 1, 60);
    got = (base + 2 < q_a.size()) ? q_a[base + 2] : 8'hxx;
    total++;
    if (got !== 8'h00) begin
      bad++; $display("FAIL rst_count: got %h want 00", got);
    end
  endtask

  task automatic test_counter_wrap();
    int base, d0;
    logic [7:0] got;
    apply_reset();
    base = q_c.size(); d0 = done_cnt_c;
    for (int f = 0; f < 257; f++) begin
      chirp = 1'b1; di = 14'(f); di_valid = 1'b1;
      tick();
      chirp = 1'b0; di_valid = 1'b0;
      wait_done(2, d0 + f + 1, 20);
    end
    total++;
    if (q_c.size() - base !== 257 * 5) begin
      bad++; $display("FAIL wrap_len: got %0d bytes want %0d", q_c.size() - base, 257 * 5);
    end
    for (int f = 0; f < 257; f++) begin
      got = (base + 5 * f + 2 < q_c.size()) ? q_c[base + 5 * f + 2] : 8'hxx;
      total++;
      if (got !== 8'(f)) begin
        bad++; $display("FAIL wrap_count%0d: got %h want %h", f, got, 8'(f));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_overflow();
    test_gating();
    test_reset_mid();
    test_counter_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
